div_nr_seq: RTL and testbench

- Sequential signed integer divider: the inverse-direction companion to the team's radix-4 Booth multiplier.
- Consumes the same 66-bit sign-extended operands and produces {remainder, quotient} on a 132-bit aluResult, with the same data_ok completion flag.
- Uses a non-restoring, one-quotient-bit-per-cycle algorithm with a start/busy/data_ok handshake.
- Sits beside the multiplier in the ALU's multi-cycle unit.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_nr_step.sv | 27 ++
 rtl/div_nr_seq.sv | 104 ++++++++++
 tb/tb_div_nr_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared state type, default width and magnitude helper for the
// sequential non-restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 66;
  localparam int ABS_MAX_W = 128;

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  // Magnitude of a w-bit two's-complement value held zero-extended in v;
  // the most negative value comes back as the unsigned 2^(w-1).
  function automatic logic [ABS_MAX_W-1:0] abs_u(input logic [ABS_MAX_W-1:0] v,
                                                 input int w);
    logic [ABS_MAX_W-1:0] mask;
    logic [ABS_MAX_W-1:0] neg;
    logic [ABS_MAX_W-1:0] top;
    mask = {ABS_MAX_W{1'b1}} >> (ABS_MAX_W - w);
    neg  = (~v + ABS_MAX_W'(1)) & mask;
    top  = v >> (w - 1);
    return top[0] ? neg : (v & mask);
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring iteration: shift {p, q} left, then add or
// subtract the divisor magnitude depending on the sign of the old remainder.
module div_nr_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic signed [WIDTH:0]   p_in,
  input  logic        [WIDTH-1:0] q_in,
  input  logic        [WIDTH-1:0] d,
  output logic signed [WIDTH:0]   p_out,
  output logic        [WIDTH-1:0] q_out
);

  logic signed [WIDTH:0] p_sh;
  logic signed [WIDTH:0] d_ext;

  // The extra remainder bit keeps 2*P within range, so the pre-shift sign is valid.
  always_comb begin
    p_sh  = {p_in[WIDTH-1:0], q_in[WIDTH-1]};
    d_ext = {1'b0, d};
    if (p_in[WIDTH]) p_out = p_sh + d_ext;
    else             p_out = p_sh - d_ext;
    q_out = {q_in[WIDTH-2:0], ~p_out[WIDTH]};
  end

endmodule

// File: rtl/div_nr_seq.sv
// Sequential signed divider, one quotient bit per cycle, truncating semantics.
// aluResult = {remainder, quotient}; data_ok is a level held until the next start.
module div_nr_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 data_ok,
  output logic [2*WIDTH-1:0]   aluResult
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 state;
  logic signed [WIDTH:0]  p;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       abs_y;
  logic [WIDTH-1:0]       x_reg;
  logic                   sign_q;
  logic                   sign_r;
  logic                   div0;
  logic [CW-1:0]          count;

  logic signed [WIDTH:0]  p_next;
  logic [WIDTH-1:0]       q_next;
  logic [WIDTH-1:0]       rem_mag;
  logic [WIDTH-1:0]       quo;
  logic [WIDTH-1:0]       rem;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p),
    .q_in  (q),
    .d     (abs_y),
    .p_out (p_next),
    .q_out (q_next)
  );

  // Final remainder restore plus sign application; negation wraps, so
  // min / -1 yields min with no saturation.
  always_comb begin
    rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + abs_y) : p[WIDTH-1:0];
    quo     = sign_q ? -q : q;
    rem     = sign_r ? -rem_mag : rem_mag;
    if (div0) begin
      quo = '1;
      rem = x_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      data_ok   <= 1'b0;
      aluResult <= '0;
      p         <= '0;
      q         <= '0;
      abs_y     <= '0;
      x_reg     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div0      <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q       <= WIDTH'(abs_u(ABS_MAX_W'(X), WIDTH));
            abs_y   <= WIDTH'(abs_u(ABS_MAX_W'(Y), WIDTH));
            x_reg   <= X;
            sign_q  <= X[WIDTH-1] ^ Y[WIDTH-1];
            sign_r  <= X[WIDTH-1];
            div0    <= (Y == '0);
            p       <= '0;
            count   <= '0;
            data_ok <= 1'b0;
            busy    <= 1'b1;
            state   <= DIV;
          end
        end
        DIV: begin
          p     <= p_next;
          q     <= q_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          aluResult <= {rem, quo};
          busy      <= 1'b0;
          data_ok   <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nr_seq.sv
// Scoreboarded bench for div_nr_seq: directed sign/edge/handshake/reset cases
// followed by a randomized signed regression against a wide-arithmetic model.
module tb_div_nr_seq;

  localparam int W = 66;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] exp;
    int             cyc;
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   X = '0;
  logic [W-1:0]   Y = '0;
  logic           busy;
  logic           data_ok;
  logic [2*W-1:0] aluResult;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  item_t sb[$];
  logic  prev_ok = 1'b0;

  div_nr_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .busy      (busy),
    .data_ok   (data_ok),
    .aluResult (aluResult)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Truncating signed division done in double width, so min / -1 wraps naturally.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] xs;
    logic signed [2*W-1:0] ys;
    logic signed [2*W-1:0] qs;
    logic signed [2*W-1:0] rs;
    if (y == '0) return {x, {W{1'b1}}};
    xs = {{W{x[W-1]}}, x};
    ys = {{W{y[W-1]}}, y};
    qs = xs / ys;
    rs = xs % ys;
    return {rs[W-1:0], qs[W-1:0]};
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [95:0]  r;
    int           sh;
    logic [W-1:0] v;
    r  = {$urandom, $urandom, $urandom};
    sh = $urandom_range(0, 64);
    v  = W'(r) >> sh;
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [2*W-1:0] act,
                             input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the divider to be free, issues one start and
  // registers the expected result and completion cycle.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
    item_t it;
    int    n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: busy still %b after %0d cycles", busy, n);
    end
    X = x;
    Y = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X = rnd();
    Y = rnd();
    it.x   = x;
    it.y   = y;
    it.exp = model(x, y);
    it.cyc = cyc + W + 1;
    sb.push_back(it);
    checkOutput("busy_after_start", (2*W)'(busy), (2*W)'(1));
    checkOutput("ok_after_start", (2*W)'(data_ok), (2*W)'(0));
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: %0d results outstanding want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: each rising data_ok retires the oldest outstanding operation.
  always @(negedge clk) begin
    item_t        it;
    logic [W-1:0] qq;
    logic [W-1:0] rr;
    logic [W-1:0] prod;
    logic         ok;
    if (rst_n && data_ok && !prev_ok) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got %h with nothing outstanding", aluResult);
      end else begin
        it = sb.pop_front();
        checkOutput("result", aluResult, it.exp);
        checkOutput("latency", (2*W)'(cyc), (2*W)'(it.cyc));
        if (it.y != '0) begin
          qq   = aluResult[W-1:0];
          rr   = aluResult[2*W-1:W];
          prod = qq * it.y;
          ok   = ((prod + rr) == it.x) && (mag(rr) < mag(it.y)) &&
                 ((rr == '0) || (rr[W-1] == it.x[W-1]));
          checkOutput("props", (2*W)'(ok), (2*W)'(1));
        end
      end
    end
    prev_ok = data_ok;
  end

  initial begin
    logic [W-1:0] xs[8];
    logic [W-1:0] ys[8];
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", (2*W)'(busy), (2*W)'(0));
    checkOutput("reset_ok", (2*W)'(data_ok), (2*W)'(0));
    checkOutput("reset_result", aluResult, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed signs and edges");
    xs[0] = W'(100);   ys[0] = W'(7);
    xs[1] = -W'(100);  ys[1] = W'(7);
    xs[2] = W'(100);   ys[2] = -W'(7);
    xs[3] = -W'(100);  ys[3] = -W'(7);
    xs[4] = '1;        ys[4] = '1;
    xs[5] = {1'b1, {(W-1){1'b0}}}; ys[5] = '1;
    xs[6] = {1'b1, {(W-1){1'b0}}}; ys[6] = W'(1);
    xs[7] = W'(12345); ys[7] = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(xs[i], ys[i]);
      waitDone();
    end

    $display("[TB] handshake");
    applyStimulus(W'(100), W'(7));
    repeat (9) @(posedge clk);
    #1;
    X = W'(9);
    Y = W'(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    applyStimulus(W'(9), W'(3));
    waitDone();

    $display("[TB] reset mid-operation");
    applyStimulus(W'(1000), W'(33));
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_busy", (2*W)'(busy), (2*W)'(0));
    checkOutput("midrst_ok", (2*W)'(data_ok), (2*W)'(0));
    checkOutput("midrst_result", aluResult, '0);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(-W'(1000), W'(33));
    waitDone();

    $display("[TB] random regression");
    for (int i = 0; i < 1000; i++) begin
      rx = rnd();
      ry = rnd();
      if (ry == '0) ry = W'(1);
      applyStimulus(rx, ry);
    end
    waitDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
